// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: control codes,
// ALUOp/funct encodings and FSM states.
package alu_issue_ctrl_pkg;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b011;
  localparam logic [2:0] CTRL_SLT = 3'b100;
  localparam logic [2:0] CTRL_NOT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational ALUOp/funct to ALU control decode; also usable by
// the single-cycle datapath.
module alu_ctrl_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] ctrl,
  output logic       err
);

  always_comb begin
    ctrl = CTRL_NOT;
    err  = 1'b0;
    unique case (1'b1)
      aluop == ALUOP_ADD: ctrl = CTRL_ADD;
      aluop == ALUOP_SUB: ctrl = CTRL_SUB;
      aluop == ALUOP_OR:  ctrl = CTRL_OR;
      aluop == ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_SLT: ctrl = CTRL_SLT;
          default: begin
            ctrl = CTRL_NOT;
            err  = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: request -> registered ALU operands -> response.
// Optional ALU_ILLEGAL_TRAP_EN answers illegal funct without issuing.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [width-1:0] req_a,
  input  logic [width-1:0] req_b,
  output logic [width-1:0] alu_a,
  output logic [width-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [width-1:0] alu_out,
  input  logic [1:0]       alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_t     state, state_nxt;
  logic [2:0] dec_ctrl;
  logic       dec_err;
  logic       err_q;
  logic       accept;
  logic       trap;
  logic       unused_zero;

  assign unused_zero = alu_zero[1];

  alu_ctrl_decode u_dec (
    .aluop (req_aluop),
    .funct (req_funct),
    .ctrl  (dec_ctrl),
    .err   (dec_err)
  );

  assign req_ready = (state == S_IDLE) |
                     ((state == S_RESP) & rsp_ready);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state == S_RESP);

`ifdef ALU_ILLEGAL_TRAP_EN
  assign trap = dec_err;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = trap ? S_RESP : S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          if (accept) state_nxt = trap ? S_RESP : S_EXEC;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= CTRL_AND;
      err_q      <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept && !trap) begin
        alu_a    <= req_a;
        alu_b    <= req_b;
        alu_ctrl <= dec_ctrl;
        err_q    <= dec_err;
      end
      // trapped requests bypass the ALU and answer directly
      if (state == S_EXEC) begin
        rsp_result <= alu_out;
        rsp_zero   <= alu_zero[0];
        rsp_err    <= err_q;
      end else if (accept && trap) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b1;
        rsp_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU.
// Build with ALU_ILLEGAL_TRAP_EN to exercise the trap path.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_aluop = 2'b00;
  logic [5:0]  req_funct = 6'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctrl;
  logic [1:0]  alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err)
  );

  // bit1 of zero is driven opposite to bit0 so a wrong-bit capture shows
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_out = alu_a & alu_b;
      3'b001:  alu_out = alu_a | alu_b;
      3'b010:  alu_out = alu_a + alu_b;
      3'b011:  alu_out = alu_a - alu_b;
      3'b100:  alu_out = {31'b0, alu_a < alu_b};
      default: alu_out = ~alu_a;
    endcase
    alu_zero = {alu_out != 0, alu_out == 0};
  end

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic        held = 1'b0;
  logic [31:0] h_res;
  logic        h_zero, h_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && rsp_valid) begin
        chk("hold_result", rsp_result, h_res);
        chk("hold_zero", 32'(rsp_zero), 32'(h_zero));
        chk("hold_err", 32'(rsp_err), 32'(h_err));
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_result), 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        held = 1'b0;
      end else if (rsp_valid) begin
        held   = 1'b1;
        h_res  = rsp_result;
        h_zero = rsp_zero;
        h_err  = rsp_err;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // call at posedge+1; returns at posedge+1 right after the handshake
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ez,
                      input logic ee, input bit push);
    req_valid = 1'b1;
    req_aluop = op;
    req_funct = fn;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        if (push) q.push_back('{er, ez, ee});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0 && !rsp_valid) return;
      tick(1);
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b, res;
    logic        zero;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'b01, 6'h00, 32'h1234, 32'h1234, 32'h0, 1'b1};
    vecs[1] = '{2'b11, 6'h00, 32'hF0, 32'h0F, 32'hFF, 1'b0};
    vecs[2] = '{2'b10, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0,
                32'h0F000F00, 1'b0};
    vecs[3] = '{2'b10, 6'b100010, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0};
    vecs[4] = '{2'b00, 6'h3F, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1};
    vecs[5] = '{2'b10, 6'b101010, 32'h80000000, 32'd1, 32'h0, 1'b1};
    vecs[6] = '{2'b10, 6'b100101, 32'hA0, 32'h05, 32'hA5, 1'b0};

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    tick(1);

    // reset while in EXEC drops the request
    send(2'b10, 6'b100000, 32'd40, 32'd2, 32'd0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    tick(1);

    rsp_ready = 1'b1;
    send(2'b10, 6'b100000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);
    @(negedge clk);
    chk("add_alu_ctrl", 32'(alu_ctrl), 32'b010);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_t1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("add_t2_rsp_valid", 32'(rsp_valid), 32'd1);
    tick(1);

    foreach (vecs[i])
      send(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b,
           vecs[i].res, vecs[i].zero, 1'b0, 1);
    drain();

    // backpressure, then a second request accepted as rsp_ready rises
    rsp_ready = 1'b0;
    send(2'b10, 6'b101010, 32'd3, 32'd9, 32'd1, 1'b0, 1'b0, 1);
    tick(1);
    req_valid = 1'b1;
    req_aluop = 2'b00;
    req_funct = 6'h00;
    req_a     = 32'd10;
    req_b     = 32'd20;
    q.push_back('{32'd30, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result, 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_result", rsp_result, 32'd30);
    tick(1);
    drain();

`ifdef ALU_ILLEGAL_TRAP_EN
    send(2'b10, 6'b000000, 32'h0000FFFF, 32'd0,
         32'd0, 1'b1, 1'b1, 1);
    @(negedge clk);
    chk("trap_t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("trap_alu_ctrl_held", 32'(alu_ctrl), 32'b010);
    chk("trap_alu_a_held", alu_a, 32'd10);
`else
    send(2'b10, 6'b000000, 32'h0000FFFF, 32'd0,
         32'hFFFF0000, 1'b0, 1'b1, 1);
    @(negedge clk);
    chk("illegal_alu_ctrl", 32'(alu_ctrl), 32'b111);
    chk("illegal_t1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("illegal_t2_rsp_valid", 32'(rsp_valid), 32'd1);
`endif
    tick(1);
    drain();

    // legal op after an illegal one clears the error flag
    send(2'b00, 6'h00, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1);
    drain();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
